// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the memory arbiter slice.
//   arb_state_t        - arbiter FSM state (IDLE / IFETCH / DATA)
//   TIMEOUT_CYCLES_DEF - default wait budget before a granted request is aborted
//   fetch_hit()        - fetch-buffer hit test used for StallMemF
`timescale 1ns/1ps
package mem_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_IFETCH = 2'd1,
    ST_DATA   = 2'd2
  } arb_state_t;

  localparam int TIMEOUT_CYCLES_DEF = 255;

  function automatic logic fetch_hit(input logic valid, input logic [31:0] buf_addr,
                                     input logic [31:0] pc);
    return valid && (buf_addr == pc);
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: pipeline-side and shared-memory-side signals of the arbiter.
//   Pipeline fetch : PCF in, InstrF / StallMemF out
//   Pipeline data  : MemReqM, MemWriteM, ALUOutM, WriteDataM in; ReadDataM, StallMemM, MemErr out
//   Shared memory  : MemReq, MemWe, MemAddr, MemWData out; MemRData, MemReady in
// Handshake: MemReq is the request valid; it rises with MemWe/MemAddr/MemWData
// already stable and all four hold unchanged until the cycle MemReady=1 is seen
// while MemReq=1 (or the wait budget expires). MemReady is a one-cycle completion
// pulse, MemRData is only meaningful in that cycle, and MemReady with MemReq=0 is
// ignored.
// Modports: slave = arbiter, master = pipeline + memory environment.
`timescale 1ns/1ps
interface mem_arbiter_if;
  logic [31:0] PCF;
  logic [31:0] InstrF;
  logic        StallMemF;
  logic        MemReqM;
  logic        MemWriteM;
  logic [31:0] ALUOutM;
  logic [31:0] WriteDataM;
  logic [31:0] ReadDataM;
  logic        StallMemM;
  logic        MemErr;
  logic        MemReq;
  logic        MemWe;
  logic [31:0] MemAddr;
  logic [31:0] MemWData;
  logic [31:0] MemRData;
  logic        MemReady;

  modport slave (
    input  PCF, MemReqM, MemWriteM, ALUOutM, WriteDataM, MemRData, MemReady,
    output InstrF, StallMemF, ReadDataM, StallMemM, MemErr, MemReq, MemWe, MemAddr, MemWData
  );

  modport master (
    output PCF, MemReqM, MemWriteM, ALUOutM, WriteDataM, MemRData, MemReady,
    input  InstrF, StallMemF, ReadDataM, StallMemM, MemErr, MemReq, MemWe, MemAddr, MemWData
  );
endinterface

// File: rtl/mem_arb_perf.sv
// mem_arb_perf: free-running 32-bit event counters for the arbiter (wrap at 2^32).
//   clk, reset     - clock, asynchronous active-low reset
//   i_fetch_done   - one-cycle pulse per completed fetch transaction
//   i_data_done    - one-cycle pulse per completed data transaction
//   i_stall        - high on every cycle with any pipeline stall
//   o_perf_fetch / o_perf_data / o_perf_stall - counter values
`timescale 1ns/1ps
module mem_arb_perf (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_fetch_done,
  input  logic        i_data_done,
  input  logic        i_stall,
  output logic [31:0] o_perf_fetch,
  output logic [31:0] o_perf_data,
  output logic [31:0] o_perf_stall
);
  logic [31:0] r_fetch, r_data, r_stall;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fetch <= 32'd0;
      r_data  <= 32'd0;
      r_stall <= 32'd0;
    end else begin
      if (i_fetch_done) r_fetch <= r_fetch + 32'd1;
      if (i_data_done)  r_data  <= r_data + 32'd1;
      if (i_stall)      r_stall <= r_stall + 32'd1;
    end
  end

  assign o_perf_fetch = r_fetch;
  assign o_perf_data  = r_data;
  assign o_perf_stall = r_stall;
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between instruction fetch and the
// Memory-stage data access, one transaction outstanding at a time; data wins
// when both want the port.
//   clk, reset   - clock, asynchronous active-low reset
//   bus          - mem_arbiter_if.slave (pipeline and memory signals)
//   o_dbg_state  - current FSM state, for observation only
//   PerfFetch / PerfData / PerfStall - event counters, present only when
//                  MEM_ARB_PERF_EN is defined
// Parameter TIMEOUT_CYCLES: MemReady-low cycles tolerated before an abort.
`timescale 1ns/1ps
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF
) (
  input  logic          clk,
  input  logic          reset,
  mem_arbiter_if.slave  bus,
  output arb_state_t    o_dbg_state
`ifdef MEM_ARB_PERF_EN
  ,
  output logic [31:0]   PerfFetch,
  output logic [31:0]   PerfData,
  output logic [31:0]   PerfStall
`endif
);

  arb_state_t  r_state, w_next;
  logic        r_fbuf_valid;
  logic [31:0] r_fbuf_addr, r_fbuf_data, r_rdata;
  logic        r_data_done, r_err;
  logic        r_mem_req, r_mem_we;
  logic [31:0] r_mem_addr, r_mem_wdata, r_wait;

  logic        w_fetch_miss, w_data_pend, w_ready, w_timeout, w_done;
  logic        w_grant_data, w_grant_fetch, w_fetch_cmp, w_data_cmp;
  logic [31:0] w_rsp_data;

  assign w_fetch_miss = !fetch_hit(r_fbuf_valid, r_fbuf_addr, bus.PCF);
  assign w_data_pend  = bus.MemReqM && !r_data_done;
  assign w_ready      = r_mem_req && bus.MemReady;
  // Abort on the last budgeted wait cycle so MemReq is high for exactly
  // TIMEOUT_CYCLES cycles.
  assign w_timeout    = r_mem_req && !bus.MemReady && (r_wait == 32'(TIMEOUT_CYCLES - 1));
  assign w_done       = w_ready || w_timeout;
  assign w_rsp_data   = w_ready ? bus.MemRData : 32'd0;
  assign w_fetch_cmp  = w_done && (r_state == ST_IFETCH);
  assign w_data_cmp   = w_done && (r_state == ST_DATA);

  always_comb begin
    w_next        = r_state;
    w_grant_data  = 1'b0;
    w_grant_fetch = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_data_pend) begin
          w_next       = ST_DATA;
          w_grant_data = 1'b1;
        end else if (w_fetch_miss) begin
          w_next        = ST_IFETCH;
          w_grant_fetch = 1'b1;
        end
      end
      ST_IFETCH, ST_DATA: begin
        if (w_done) w_next = ST_IDLE;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  // Request registers are loaded at grant so the memory sees a fully stable
  // request from the first MemReq cycle, independent of later pipeline changes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= 32'd0;
      r_mem_wdata <= 32'd0;
    end else if (w_grant_data) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= bus.MemWriteM;
      r_mem_addr  <= bus.ALUOutM;
      r_mem_wdata <= bus.WriteDataM;
    end else if (w_grant_fetch) begin
      r_mem_req   <= 1'b1;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= bus.PCF;
      r_mem_wdata <= 32'd0;
    end else if (w_done) begin
      r_mem_req   <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)                     r_wait <= 32'd0;
    else if (w_done || !r_mem_req)  r_wait <= 32'd0;
    else if (!bus.MemReady)         r_wait <= r_wait + 32'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_fbuf_valid <= 1'b0;
      r_fbuf_addr  <= 32'd0;
      r_fbuf_data  <= 32'd0;
      r_rdata      <= 32'd0;
      r_data_done  <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      // The fetch result is filed under the captured address, so a PC that
      // moved on during the fetch simply misses again afterwards.
      if (w_fetch_cmp) begin
        r_fbuf_valid <= 1'b1;
        r_fbuf_addr  <= r_mem_addr;
        r_fbuf_data  <= w_rsp_data;
      end
      if (w_data_cmp && !r_mem_we) r_rdata <= w_rsp_data;
      if (w_timeout) r_err <= 1'b1;
      // Completion outranks the advance-clear so a finished access is never lost.
      if (w_data_cmp)                           r_data_done <= 1'b1;
      else if (!w_fetch_miss && !w_data_pend)   r_data_done <= 1'b0;
    end
  end

  assign bus.InstrF    = r_fbuf_data;
  assign bus.StallMemF = w_fetch_miss;
  assign bus.ReadDataM = r_rdata;
  assign bus.StallMemM = w_data_pend;
  assign bus.MemErr    = r_err;
  assign bus.MemReq    = r_mem_req;
  assign bus.MemWe     = r_mem_we;
  assign bus.MemAddr   = r_mem_addr;
  assign bus.MemWData  = r_mem_wdata;
  assign o_dbg_state   = r_state;

`ifdef MEM_ARB_PERF_EN
  logic w_any_stall;
  assign w_any_stall = w_fetch_miss || w_data_pend;

  mem_arb_perf u_perf (
    .clk          (clk),
    .reset        (reset),
    .i_fetch_done (w_fetch_cmp),
    .i_data_done  (w_data_cmp),
    .i_stall      (w_any_stall),
    .o_perf_fetch (PerfFetch),
    .o_perf_data  (PerfData),
    .o_perf_stall (PerfStall)
  );
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
`timescale 1ns/1ps
module tb_mem_arbiter;
  import mem_arb_pkg::*;

  localparam int TO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  arb_state_t dbg_state;
  mem_arbiter_if bus();
`ifdef MEM_ARB_PERF_EN
  logic [31:0] perf_fetch, perf_data, perf_stall;
`endif

  mem_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk         (clk),
    .reset       (reset),
    .bus         (bus),
    .o_dbg_state (dbg_state)
`ifdef MEM_ARB_PERF_EN
    ,
    .PerfFetch   (perf_fetch),
    .PerfData    (perf_data),
    .PerfStall   (perf_stall)
`endif
  );

  // ---------------- scoreboard ----------------
  typedef struct {
    logic        is_data;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    int          lat;     // MemReady-low cycles before the memory answers
  } txn_t;

  txn_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // model state: what the arbiter must be showing, derived from the rules
  logic        m_fv, m_dd, m_err, m_gap, in_txn, spurious_ready;
  logic [31:0] m_fa, m_fd, m_rd;
  logic        m_exp_sf, m_exp_sm, fin, tmo;
  int          waits;
  txn_t        cur;

  function automatic txn_t mk(input logic d, input logic we, input logic [31:0] a,
                              input logic [31:0] wd, input logic [31:0] rd, input int lat);
    txn_t t;
    t.is_data = d; t.we = we; t.addr = a; t.wdata = wd; t.rdata = rd; t.lat = lat;
    return t;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- compare process + memory responder ----------------
  initial begin
    bus.MemReady = 1'b0;
    bus.MemRData = 32'd0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        check1("rst_memreq", bus.MemReq, 1'b0);
        check32("rst_instr", bus.InstrF, 32'd0);
        check32("rst_rdata", bus.ReadDataM, 32'd0);
        check1("rst_err", bus.MemErr, 1'b0);
        m_fv = 0; m_fa = 0; m_fd = 0; m_rd = 0; m_dd = 0; m_err = 0;
        in_txn = 0; m_gap = 0; waits = 0;
        bus.MemReady = 1'b0;
        bus.MemRData = 32'd0;
      end else begin
        m_exp_sf = !(m_fv && (m_fa == bus.PCF));
        m_exp_sm = bus.MemReqM && !m_dd;
        check1("stall_f", bus.StallMemF, m_exp_sf);
        check1("stall_m", bus.StallMemM, m_exp_sm);
        check32("instr_f", bus.InstrF, m_fd);
        check32("read_data", bus.ReadDataM, m_rd);
        check1("mem_err", bus.MemErr, m_err);
        if (m_gap) check1("req_gap", bus.MemReq, 1'b0);
        m_gap = 0;
        fin = 0;
        tmo = 0;
        if (bus.MemReq) begin
          if (!in_txn) begin
            in_txn = 1;
            waits = 0;
            checks++;
            if (exp_q.size() == 0) begin
              errors++;
              $display("FAIL txn_unexpected: got request addr 0x%08h expected none", bus.MemAddr);
              cur = mk(1'b0, 1'b0, 32'd0, 32'd0, 32'd0, 0);
            end else begin
              cur = exp_q.pop_front();
            end
          end
          check1("txn_we", bus.MemWe, cur.we);
          check32("txn_addr", bus.MemAddr, cur.addr);
          if (cur.we) check32("txn_wdata", bus.MemWData, cur.wdata);
          if (waits == cur.lat) begin
            bus.MemReady = 1'b1;
            bus.MemRData = cur.rdata;
            fin = 1;
          end else begin
            bus.MemReady = 1'b0;
            bus.MemRData = 32'hBAD0BAD0;
            waits++;
            if (waits == TO) begin
              fin = 1;
              tmo = 1;
            end
          end
        end else begin
          if (in_txn) begin
            checks++;
            errors++;
            $display("FAIL req_held: got MemReq 0 expected 1 at %0t", $time);
            in_txn = 0;
          end
          bus.MemReady = spurious_ready;
          bus.MemRData = 32'hBAD0BAD0;
        end
        // effects of the clock edge that ends this cycle
        if (!m_exp_sf && !m_exp_sm) m_dd = 0;
        if (fin) begin
          in_txn = 0;
          m_gap = 1;
          if (cur.is_data) begin
            m_dd = 1;
            if (!cur.we) m_rd = tmo ? 32'd0 : cur.rdata;
          end else begin
            m_fv = 1;
            m_fa = cur.addr;
            m_fd = tmo ? 32'd0 : cur.rdata;
          end
          if (tmo) m_err = 1;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drop_m();
    step();
    bus.MemReqM = 1'b0;
  endtask

  // Wait for a cycle with no stall (pipeline advances), then retire the access.
  task automatic advance(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((bus.StallMemF || bus.StallMemM) && n < budget);
    checks++;
    if (bus.StallMemF || bus.StallMemM) begin
      errors++;
      $display("FAIL advance_timeout: got stall_f %b stall_m %b expected both 0 within %0d cycles",
               bus.StallMemF, bus.StallMemM, budget);
    end
    drop_m();
  endtask

  task automatic set_data(input logic we, input logic [31:0] a, input logic [31:0] wd);
    bus.MemReqM    = 1'b1;
    bus.MemWriteM  = we;
    bus.ALUOutM    = a;
    bus.WriteDataM = wd;
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    reset = 1'b0;
    spurious_ready = 1'b0;
    bus.PCF = 32'h0;
    bus.MemReqM = 1'b0;
    bus.MemWriteM = 1'b0;
    bus.ALUOutM = 32'h0;
    bus.WriteDataM = 32'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check32("rst_state", 32'(dbg_state), 32'(ST_IDLE));

    // zero-wait fetch after reset
    exp_q.push_back(mk(1'b0, 1'b0, 32'h0, 32'h0, 32'hE3A01005, 0));
    step(); reset = 1'b1;
    @(negedge clk);
    check1("zw_miss_c0", bus.StallMemF, 1'b1);
    check1("zw_req_c0", bus.MemReq, 1'b0);
    @(negedge clk);
    check1("zw_req_c1", bus.MemReq, 1'b1);
    check32("zw_addr_c1", bus.MemAddr, 32'h0);
    @(negedge clk);
    check1("zw_stall_c2", bus.StallMemF, 1'b0);
    check32("zw_instr_c2", bus.InstrF, 32'hE3A01005);

    // simultaneous fetch miss and load: data first
    step();
    bus.PCF = 32'h8;
    set_data(1'b0, 32'h100, 32'h0);
    exp_q.push_back(mk(1'b1, 1'b0, 32'h100, 32'h0, 32'h11112222, 1));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h8, 32'h0, 32'hE1A00000, 0));
    @(negedge clk);
    @(negedge clk);
    check32("pri_first_addr", bus.MemAddr, 32'h100);
    repeat (3) @(negedge clk);
    check32("pri_second_addr", bus.MemAddr, 32'h8);
    advance(20);

    // store with 3 wait cycles
    set_data(1'b1, 32'h200, 32'hDEADBEEF);
    exp_q.push_back(mk(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, 32'h0, 3));
    @(negedge clk);
    check32("pri_rdata", bus.ReadDataM, 32'h11112222);
    check32("pri_instr", bus.InstrF, 32'hE1A00000);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check1("st_we", bus.MemWe, 1'b1);
      check32("st_wdata", bus.MemWData, 32'hDEADBEEF);
    end
    check1("st_stall_last", bus.StallMemM, 1'b1);
    @(negedge clk);
    check1("st_stall_done", bus.StallMemM, 1'b0);
    drop_m();

    // PC moves while a fetch is in flight
    bus.PCF = 32'h40;
    exp_q.push_back(mk(1'b0, 1'b0, 32'h40, 32'h0, 32'hAAAA0040, 2));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h44, 32'h0, 32'hBBBB0044, 0));
    step();
    bus.PCF = 32'h44;
    @(negedge clk);
    check32("pcchg_addr", bus.MemAddr, 32'h40);
    repeat (3) @(negedge clk);
    check1("pcchg_miss", bus.StallMemF, 1'b1);
    check32("pcchg_old", bus.InstrF, 32'hAAAA0040);
    repeat (2) @(negedge clk);
    check32("pcchg_new", bus.InstrF, 32'hBBBB0044);

    // identical load held across an advance issues twice
    step();
    set_data(1'b0, 32'h300, 32'h0);
    exp_q.push_back(mk(1'b1, 1'b0, 32'h300, 32'h0, 32'h33330001, 0));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h300, 32'h0, 32'h33330002, 0));
    repeat (3) @(negedge clk);
    check32("b2b_first", bus.ReadDataM, 32'h33330001);
    @(negedge clk);
    check1("b2b_restall", bus.StallMemM, 1'b1);
    repeat (2) @(negedge clk);
    check32("b2b_second", bus.ReadDataM, 32'h33330002);
    drop_m();

    // MemReady while MemReq is low must be ignored
    spurious_ready = 1'b1;
    repeat (3) step();
    set_data(1'b0, 32'h380, 32'h0);
    exp_q.push_back(mk(1'b1, 1'b0, 32'h380, 32'h0, 32'h38383838, 2));
    step();
    spurious_ready = 1'b0;
    advance(20);
    @(negedge clk);
    check32("spur_rdata", bus.ReadDataM, 32'h38383838);

    // timeout: memory never answers
    step();
    set_data(1'b0, 32'h400, 32'h0);
    exp_q.push_back(mk(1'b1, 1'b0, 32'h400, 32'h0, 32'h0, 99));
    @(negedge clk);
    repeat (4) @(negedge clk);
    check1("to_req_last", bus.MemReq, 1'b1);
    @(negedge clk);
    check1("to_req_drop", bus.MemReq, 1'b0);
    check1("to_err", bus.MemErr, 1'b1);
    check32("to_rdata", bus.ReadDataM, 32'h0);
    drop_m();
    repeat (3) step();
    check1("to_err_sticky", bus.MemErr, 1'b1);

    // reset in the middle of a data access, then reissue
    set_data(1'b0, 32'h500, 32'h0);
    exp_q.push_back(mk(1'b1, 1'b0, 32'h500, 32'h0, 32'h0BAD0500, 3));
    step();
    step();
    reset = 1'b0;
    @(negedge clk);
    check1("mid_rst_req", bus.MemReq, 1'b0);
    check32("mid_rst_state", 32'(dbg_state), 32'(ST_IDLE));
    exp_q.push_back(mk(1'b1, 1'b0, 32'h500, 32'h0, 32'h55550500, 0));
    exp_q.push_back(mk(1'b0, 1'b0, 32'h44, 32'h0, 32'h44440044, 1));
    step();
    reset = 1'b1;
    advance(30);
    @(negedge clk);
    check32("reissue_rdata", bus.ReadDataM, 32'h55550500);
    check32("reissue_instr", bus.InstrF, 32'h44440044);

    repeat (3) @(posedge clk);
    check32("queue_empty", 32'(exp_q.size()), 32'd0);
    check1("txn_idle", in_txn, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000ns");
    $fatal(1, "watchdog");
  end

endmodule
